// File: rtl/nioshello_mem_checker.sv
// nioshello_mem_checker
// Avalon-MM self-test / scrub master for the on-chip memory. A run writes the
// pattern seed+i to word addresses base+i (i = 0..length-1, addresses wrap
// modulo 2^ADDR_W), then reads the region back with up to MAX_PENDING
// outstanding pipelined reads and compares every returned word.
//
// Ports
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   start                 : begin a run; only honoured while idle
//   base_addr/length/seed : run parameters, latched when the run starts
//   busy                  : run in progress (falls together with done)
//   done                  : one-cycle end-of-run pulse
//   error_count           : mismatches in the last run, saturating at 0xFFFF
//   first_err_addr        : word address of the first mismatch, 0 if none
//   avm_*                 : Avalon-MM master port; every output is registered
module nioshello_mem_checker #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [15:0]           length,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           error_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid
);

  localparam int         BE_W  = DATA_W / 8;
  localparam logic [3:0] MAX_P = 4'(MAX_PENDING);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [16:0]         len_q, len_d;      // one extra bit so indices can reach length
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [16:0]         wi_q, wi_d;        // write index
  logic [16:0]         ri_q, ri_d;        // read issue index
  logic [16:0]         ci_q, ci_d;        // compare (return) index
  logic [3:0]          pend_q, pend_d;
  logic                err_seen_q, err_seen_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   first_err_q, first_err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;

  logic                wr_acc_s;
  logic                rd_acc_s;
  logic                rdv_s;
  logic                mismatch_s;
  logic [16:0]         wi_nx_s;
  logic [16:0]         ri_nx_s;
  logic [16:0]         ci_nx_s;
  logic [3:0]          pend_nx_s;
  logic [DATA_W-1:0]   exp_data_s;

  assign wr_acc_s   = wr_q & ~avm_waitrequest;
  assign rd_acc_s   = rd_q & ~avm_waitrequest;
  // Returns only count while a run is reading and something is outstanding;
  // stray pulses in IDLE/DONE (or after a reset) are dropped here.
  assign rdv_s      = avm_readdatavalid && ((state_q == S_READ) || (state_q == S_DRAIN))
                      && (pend_q != 4'd0);
  assign exp_data_s = seed_q + DATA_W'(ci_q);
  assign mismatch_s = rdv_s && (avm_readdata != exp_data_s);
  assign wi_nx_s    = wi_q + 17'd1;
  assign ri_nx_s    = rd_acc_s ? (ri_q + 17'd1) : ri_q;
  assign ci_nx_s    = rdv_s ? (ci_q + 17'd1) : ci_q;

  // Outstanding-read count after this cycle; accept+return together cancel.
  always_comb begin
    case ({rd_acc_s, rdv_s})
      2'b10:   pend_nx_s = pend_q + 4'd1;
      2'b01:   pend_nx_s = pend_q - 4'd1;
      default: pend_nx_s = pend_q;
    endcase
  end

  // Next-state, bus-request and result computation.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    seed_d      = seed_q;
    wi_d        = wi_q;
    ri_d        = ri_q;
    ci_d        = ci_q;
    pend_d      = pend_q;
    err_seen_d  = err_seen_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;
    be_d        = '0;

    if (mismatch_s) begin
      if (err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end else begin
        err_cnt_d = err_cnt_q;
      end
      if (!err_seen_q) begin
        first_err_d = base_q + ADDR_W'(ci_q);
        err_seen_d  = 1'b1;
      end else begin
        first_err_d = first_err_q;
      end
    end else begin
      err_cnt_d = err_cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d      = base_addr;
          len_d       = {1'b0, length};
          seed_d      = seed;
          wi_d        = '0;
          ri_d        = '0;
          ci_d        = '0;
          pend_d      = '0;
          err_seen_d  = 1'b0;
          err_cnt_d   = '0;
          first_err_d = '0;
          busy_d      = 1'b1;
          if (length != 16'd0) begin
            state_d = S_WRITE;
            wr_d    = 1'b1;
            addr_d  = base_addr;
            wdata_d = seed;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          busy_d = 1'b0;
        end
      end

      S_WRITE: begin
        if (wr_acc_s) begin
          wi_d = wi_nx_s;
          if (wi_nx_s == len_q) begin
            // Last write accepted: present the first read straight away.
            state_d = S_READ;
            rd_d    = 1'b1;
            addr_d  = base_q;
          end else begin
            wr_d    = 1'b1;
            addr_d  = base_q + ADDR_W'(wi_nx_s);
            wdata_d = seed_q + DATA_W'(wi_nx_s);
          end
        end else begin
          wr_d    = 1'b1;
          addr_d  = addr_q;
          wdata_d = wdata_q;
        end
      end

      S_READ: begin
        ri_d   = ri_nx_s;
        ci_d   = ci_nx_s;
        pend_d = pend_nx_s;
        if (rd_q && avm_waitrequest) begin
          rd_d   = 1'b1;
          addr_d = addr_q;
        end else if (ri_nx_s == len_q) begin
          if (ci_nx_s == len_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (pend_nx_s < MAX_P) begin
          rd_d   = 1'b1;
          addr_d = base_q + ADDR_W'(ri_nx_s);
        end else begin
          rd_d = 1'b0;
        end
      end

      S_DRAIN: begin
        ci_d   = ci_nx_s;
        pend_d = pend_nx_s;
        if (ci_nx_s == len_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (rd_d || wr_d) begin
      be_d = '1;
    end else begin
      be_d = '0;
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      seed_q      <= '0;
      wi_q        <= '0;
      ri_q        <= '0;
      ci_q        <= '0;
      pend_q      <= '0;
      err_seen_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      seed_q      <= seed_d;
      wi_q        <= wi_d;
      ri_q        <= ri_d;
      ci_q        <= ci_d;
      pend_q      <= pend_d;
      err_seen_q  <= err_seen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error_count    = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;

endmodule

// File: tb/tb_nioshello_mem_checker.sv
// Bench for nioshello_mem_checker: Avalon-MM memory slave model with
// configurable read latency, stall pattern and data corruption; a table of
// run vectors plus hand-written length-0, reset-mid-read and wrap sequences.
module tb_nioshello_mem_checker;

  localparam int ADDR_W      = 15;
  localparam int DATA_W      = 32;
  localparam int MAX_PENDING = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [14:0]       base_addr;
  logic [15:0]       length;
  logic [31:0]       seed;
  logic              busy;
  logic              done;
  logic [15:0]       error_count;
  logic [14:0]       first_err_addr;
  logic [14:0]       avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;

  always #5 clk = ~clk;

  nioshello_mem_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .seed(seed), .busy(busy), .done(done),
    .error_count(error_count), .first_err_addr(first_err_addr),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  int checks = 0;
  int failures = 0;

  // Slave configuration, written only by the stimulus process.
  int          lat_cfg = 1;
  bit          stall_cfg = 1'b0;
  bit          hold_wait = 1'b0;
  bit          slv_clear = 1'b0;
  logic [1:0]  cen_cfg = 2'b00;
  logic [14:0] c0_cfg = 15'h0;
  logic [14:0] c1_cfg = 15'h0;
  logic [31:0] late_xor = 32'h0;
  logic [14:0] exp_base = 15'h0;
  logic [31:0] exp_seed = 32'h0;

  // Slave state, written only by the slave process.
  typedef struct { logic [31:0] data; int due; } ret_t;
  logic [31:0] mem [0:32767];
  ret_t        rq[$];
  int cyc = 0, wr_n = 0, rd_n = 0, ret_n = 0, wr_bad = 0, rd_bad = 0, be_bad = 0;
  int stab_viol = 0, stall_cyc = 0, both_n = 0, pend_n = 0, req_idx = 0, stall_left = 0;
  bit          stalled_this = 1'b0, prev_wait = 1'b0, prev_req = 1'b0;
  bit          prev_rd = 1'b0, prev_wr = 1'b0;
  logic [14:0] prev_addr = 15'h0;
  logic [31:0] prev_wd = 32'h0;

  // Slave: drives response for the coming rising edge on each falling edge.
  always @(negedge clk) begin
    bit          req, w, ret_now;
    logic [31:0] d;
    ret_t        r;
    cyc = cyc + 1;
    if (slv_clear) begin
      wr_n = 0; rd_n = 0; ret_n = 0; wr_bad = 0; rd_bad = 0; be_bad = 0;
      stab_viol = 0; stall_cyc = 0; both_n = 0; pend_n = 0; req_idx = 0;
      stall_left = 0; stalled_this = 1'b0; prev_wait = 1'b0; prev_req = 1'b0;
    end
    ret_now = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata = 32'h0;
    if (rq.size() > 0) begin
      if (rq[0].due <= cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = rq[0].data ^ late_xor;
        void'(rq.pop_front());
        ret_n = ret_n + 1;
        pend_n = pend_n - 1;
        ret_now = 1'b1;
      end
    end
    req = avm_read | avm_write;
    if (prev_wait && prev_req) begin
      if (avm_read != prev_rd || avm_write != prev_wr || avm_address != prev_addr
          || avm_writedata != prev_wd) stab_viol = stab_viol + 1;
    end
    if (avm_read && avm_write) be_bad = be_bad + 1;
    if (req && avm_byteenable != 4'hF) be_bad = be_bad + 1;
    if (!req && avm_byteenable != 4'h0) be_bad = be_bad + 1;
    w = 1'b0;
    if (hold_wait) begin
      w = 1'b1;
    end else if (stall_left > 0) begin
      w = 1'b1;
      stall_left = stall_left - 1;
    end else if (req && stall_cfg && !stalled_this && (req_idx % 2 == 1)) begin
      w = 1'b1;
      stall_left = 2;
      stalled_this = 1'b1;
    end
    if (w && req) stall_cyc = stall_cyc + 1;
    avm_waitrequest = w;
    if (req && !w) begin
      if (avm_write) begin
        mem[avm_address] = avm_writedata;
        if (avm_address != 15'(exp_base + 15'(wr_n)) || avm_writedata != exp_seed + 32'(wr_n))
          wr_bad = wr_bad + 1;
        wr_n = wr_n + 1;
      end else begin
        d = mem[avm_address];
        if (cen_cfg[0] && avm_address == c0_cfg) d = d ^ 32'h0000_0100;
        if (cen_cfg[1] && avm_address == c1_cfg) d = d ^ 32'h0000_0100;
        if (avm_address != 15'(exp_base + 15'(rd_n))) rd_bad = rd_bad + 1;
        r.data = d;
        r.due = cyc + lat_cfg;
        rq.push_back(r);
        rd_n = rd_n + 1;
        pend_n = pend_n + 1;
        if (ret_now) both_n = both_n + 1;
      end
      req_idx = req_idx + 1;
      stalled_this = 1'b0;
    end
    prev_wait = w; prev_req = req; prev_rd = avm_read; prev_wr = avm_write;
    prev_addr = avm_address; prev_wd = avm_writedata;
  end

  typedef struct {
    logic [14:0] base;
    logic [15:0] len;
    logic [31:0] seed;
    int          lat;
    bit          stall;
    logic [1:0]  cen;
    logic [14:0] c0;
    logic [14:0] c1;
    bit          poke;
    logic [15:0] exp_err;
    logic [14:0] exp_first;
    int          exp_done;   // cycles from start to done, or -1 when not fixed here
    int          exp_maxp;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {28'h0, busy, done, avm_read, avm_write}, 32'h0);
    chk({tag, "_addr"}, {17'h0, avm_address}, 32'h0);
    chk({tag, "_wdata"}, avm_writedata, 32'h0);
    chk({tag, "_be"}, {28'h0, avm_byteenable}, 32'h0);
    chk({tag, "_errcnt"}, {16'h0, error_count}, 32'h0);
    chk({tag, "_firsterr"}, {17'h0, first_err_addr}, 32'h0);
  endtask

  task automatic clear_slave();
    slv_clear = 1'b1;
    @(posedge clk); #1;
    slv_clear = 1'b0;
  endtask

  task automatic run_case(input string tag, input vec_t v);
    int k, maxp, busy_low, first_rd_k;
    bit got_done;
    lat_cfg = v.lat; stall_cfg = v.stall; cen_cfg = v.cen; c0_cfg = v.c0; c1_cfg = v.c1;
    exp_base = v.base; exp_seed = v.seed;
    clear_slave();
    base_addr = v.base; length = v.len; seed = v.seed; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the run inputs to show they were latched.
    base_addr = ~v.base; length = 16'd3; seed = ~v.seed;
    k = 1;
    chk({tag, "_first_write"}, {30'h0, avm_write, busy}, 32'h3);
    chk({tag, "_first_addr"}, {17'h0, avm_address}, {17'h0, v.base});
    chk({tag, "_first_data"}, avm_writedata, v.seed);
    got_done = 1'b0; maxp = 0; busy_low = 0; first_rd_k = -1;
    while (!got_done && k < 3000) begin
      if (pend_n > maxp) maxp = pend_n;
      if (avm_read && first_rd_k < 0) first_rd_k = k;
      if (!busy) busy_low = busy_low + 1;
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (v.poke && k == 3) begin
          start = 1'b1;
          base_addr = 15'h5555;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        k = k + 1;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, {31'h0, got_done}, 32'h1);
    if (v.exp_done > 0) chk({tag, "_done_cycle"}, k, v.exp_done);
    if (!v.stall) chk({tag, "_first_read_cycle"}, first_rd_k, 32'(v.len) + 32'd1);
    chk({tag, "_busy_held"}, busy_low, 32'h0);
    chk({tag, "_errcnt"}, {16'h0, error_count}, {16'h0, v.exp_err});
    chk({tag, "_firsterr"}, {17'h0, first_err_addr}, {17'h0, v.exp_first});
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, {30'h0, done, busy}, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    chk({tag, "_writes"}, wr_n, 32'(v.len));
    chk({tag, "_reads"}, rd_n, 32'(v.len));
    chk({tag, "_returns"}, ret_n, 32'(v.len));
    chk({tag, "_wr_pattern_bad"}, wr_bad, 32'h0);
    chk({tag, "_rd_addr_bad"}, rd_bad, 32'h0);
    chk({tag, "_byteenable_bad"}, be_bad, 32'h0);
    chk({tag, "_stall_stability"}, stab_viol, 32'h0);
    chk({tag, "_stalls_seen"}, {31'h0, (stall_cyc > 0)}, {31'h0, v.stall});
    chk({tag, "_max_pending"}, maxp, v.exp_maxp);
    chk({tag, "_accept_and_return"}, {31'h0, (both_n > 0)}, 32'h1);
    chk({tag, "_errcnt_hold"}, {16'h0, error_count}, {16'h0, v.exp_err});
  endtask

  initial begin
    int waited;
    tbl[0] = '{15'h7FFE, 16'd4,  32'hFFFF_FFFE, 1, 1'b0, 2'b00, 15'h0,   15'h0,   1'b0, 16'd0, 15'h0,    10, 1};
    tbl[1] = '{15'h0010, 16'd8,  32'h0000_0000, 1, 1'b0, 2'b11, 15'h0010, 15'h0012, 1'b0, 16'd2, 15'h0010, 18, 1};
    tbl[2] = '{15'h0100, 16'd16, 32'h1234_5678, 1, 1'b1, 2'b00, 15'h0,   15'h0,   1'b0, 16'd0, 15'h0,    -1, 1};
    tbl[3] = '{15'h0200, 16'd10, 32'hA5A5_A5A5, 6, 1'b0, 2'b00, 15'h0,   15'h0,   1'b0, 16'd0, 15'h0,    -1, 4};
    tbl[4] = '{15'h0300, 16'd8,  32'h0000_0100, 1, 1'b0, 2'b00, 15'h0,   15'h0,   1'b1, 16'd0, 15'h0,    18, 1};
    tbl[5] = '{15'h7FFD, 16'd6,  32'h0000_0005, 1, 1'b0, 2'b01, 15'h0001, 15'h0,   1'b0, 16'd1, 15'h0001, 14, 1};

    reset = 1'b1; start = 1'b0; base_addr = 15'h0; length = 16'd0; seed = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_case($sformatf("vec%0d", i), tbl[i]);
    end

    // Wrapped run left its pattern around address 0.
    chk("wrap_mem_7fff", mem[15'h7FFF], 32'd7);
    chk("wrap_mem_0000", mem[15'h0000], 32'd8);
    chk("wrap_mem_0001", mem[15'h0001], 32'd9);

    // length = 0: busy and done together, no bus traffic, results cleared.
    clear_slave();
    base_addr = 15'h1234; length = 16'd0; seed = 32'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("len0_busy_done", {30'h0, busy, done}, 32'h3);
    chk("len0_no_req", {30'h0, avm_read, avm_write}, 32'h0);
    chk("len0_errcnt_cleared", {16'h0, error_count}, 32'h0);
    chk("len0_firsterr_cleared", {17'h0, first_err_addr}, 32'h0);
    @(posedge clk); #1;
    chk("len0_end", {28'h0, busy, done, avm_read, avm_write}, 32'h0);
    repeat (2) begin @(posedge clk); #1; end
    chk("len0_no_accesses", wr_n + rd_n, 32'h0);

    // Reset while three reads are outstanding and a fourth is stalled.
    lat_cfg = 8; stall_cfg = 1'b0; cen_cfg = 2'b00; exp_base = 15'h0400; exp_seed = 32'h77;
    clear_slave();
    base_addr = 15'h0400; length = 16'd10; seed = 32'h77; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waited = 0;
    while (rd_n < 3 && waited < 200) begin
      @(posedge clk); #1;
      waited = waited + 1;
    end
    chk("rst_reached_3_reads", rd_n, 32'd3);
    hold_wait = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    hold_wait = 1'b0;
    check_all_zero("rst_mid");
    chk("rst_pending3", pend_n, 32'd3);
    late_xor = 32'hFFFF_FFFF;
    repeat (12) begin @(posedge clk); #1; end
    chk("rst_late_returns", ret_n, 32'd3);
    chk("rst_no_new_reads", rd_n, 32'd3);
    chk("rst_writes_total", wr_n, 32'd10);
    chk("rst_late_errcnt", {16'h0, error_count}, 32'h0);
    chk("rst_idle", {30'h0, busy, done}, 32'h0);
    late_xor = 32'h0;

    // A fresh run after the reset completes normally (latency 3, back-to-back reads).
    run_case("after_rst", '{15'h0400, 16'd10, 32'h77, 3, 1'b0, 2'b00, 15'h0, 15'h0,
                            1'b0, 16'd0, 15'h0, 24, 3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
